// File: rtl/node_traffic_gen.sv
// Per-node mesh traffic source: Bernoulli injection from a 16-bit Galois LFSR,
// random in-mesh destinations, and a warm-up / measure / drain phase sequence.
package node_traffic_gen_pkg;
    typedef struct packed {
        logic [3:0] x_source;
        logic [3:0] y_source;
        logic [3:0] x_dest;
        logic [3:0] y_dest;
    } packet_t;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_WARMUP  = 3'd1,
        PH_MEASURE = 3'd2,
        PH_DRAIN   = 3'd3,
        PH_DONE    = 3'd4
    } phase_e;
endpackage

module node_traffic_gen
    import node_traffic_gen_pkg::*;
#(
    parameter int          X_NODES         = 4,
    parameter int          Y_NODES         = 4,
    parameter int          X_LOC           = 0,
    parameter int          Y_LOC           = 0,
    parameter int          PACKET_RATE     = 100,
    parameter int          WARMUP_PACKETS  = 1000,
    parameter int          MEASURE_PACKETS = 5000,
    parameter int          DRAIN_PACKETS   = 3000,
    parameter logic [15:0] SEED            = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_start,
    input  logic        i_en,
    output packet_t     o_data,
    output logic        o_data_val,
    output logic        o_measure,
    output logic [2:0]  o_phase,
    output logic        o_done,
    output logic [31:0] o_gen_count,
    output logic [31:0] o_sent_count
);

    localparam logic [10:0] THRESH = 11'((PACKET_RATE * 1024) / 100);

    logic [15:0] lfsr;
    phase_e      phase, phase_next, phase_after;
    logic [31:0] phase_cnt, phase_cnt_next, phase_target;
    logic        hit, active, xfer, load;
    logic [3:0]  x_dest, y_dest;
    packet_t     data_q;
    logic        val_q, measure_q;
    logic [31:0] gen_cnt, sent_cnt;

    // Skip any phase whose packet count is zero, starting the search at 'from'.
    function automatic phase_e first_active(input phase_e from);
        phase_e p;
        p = PH_DONE;
        if (DRAIN_PACKETS != 0 && from <= PH_DRAIN) p = PH_DRAIN;
        if (MEASURE_PACKETS != 0 && from <= PH_MEASURE) p = PH_MEASURE;
        if (WARMUP_PACKETS != 0 && from <= PH_WARMUP) p = PH_WARMUP;
        return p;
    endfunction

    assign hit    = {1'b0, lfsr[9:0]} < THRESH;
    assign x_dest = 4'(32'(lfsr[15:12]) % X_NODES);
    assign y_dest = 4'(32'(lfsr[13:10]) % Y_NODES);
    assign active = (phase == PH_WARMUP) || (phase == PH_MEASURE) || (phase == PH_DRAIN);

    // Handshake: a packet moves downstream on any cycle where o_data_val && i_en;
    // o_data/o_measure hold steady while o_data_val is high and i_en is low.
    assign xfer = val_q && i_en;
    assign load = active && hit && (!val_q || xfer);

    always_comb begin
        phase_next     = phase;
        phase_cnt_next = phase_cnt;
        phase_target   = '0;
        phase_after    = PH_DONE;
        case (phase)
            PH_IDLE: if (i_start) phase_next = first_active(PH_WARMUP);
            PH_WARMUP: begin
                phase_target = 32'(WARMUP_PACKETS);
                phase_after  = first_active(PH_MEASURE);
            end
            PH_MEASURE: begin
                phase_target = 32'(MEASURE_PACKETS);
                phase_after  = first_active(PH_DRAIN);
            end
            PH_DRAIN: begin
                phase_target = 32'(DRAIN_PACKETS);
                phase_after  = PH_DONE;
            end
            default: ;
        endcase
        if (load) begin
            if (phase_cnt + 32'd1 == phase_target) begin
                phase_next     = phase_after;
                phase_cnt_next = '0;
            end else begin
                phase_cnt_next = phase_cnt + 32'd1;
            end
        end
    end

    // The LFSR free-runs so the draw sequence depends only on cycles since reset.
    always_ff @(posedge clk) begin
        if (!reset_n) lfsr <= SEED;
        else          lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase     <= PH_IDLE;
            phase_cnt <= '0;
            data_q    <= '{x_source: 4'(X_LOC), y_source: 4'(Y_LOC), x_dest: 4'd0, y_dest: 4'd0};
            val_q     <= 1'b0;
            measure_q <= 1'b0;
            gen_cnt   <= '0;
            sent_cnt  <= '0;
        end else begin
            phase     <= phase_next;
            phase_cnt <= phase_cnt_next;
            if (load) begin
                data_q    <= '{x_source: 4'(X_LOC), y_source: 4'(Y_LOC), x_dest: x_dest, y_dest: y_dest};
                val_q     <= 1'b1;
                measure_q <= (phase == PH_MEASURE);
                gen_cnt   <= gen_cnt + 32'd1;
            end else if (xfer) begin
                val_q <= 1'b0;
            end
            if (xfer) sent_cnt <= sent_cnt + 32'd1;
        end
    end

    assign o_data       = data_q;
    assign o_data_val   = val_q;
    assign o_measure    = measure_q;
    assign o_phase      = phase;
    assign o_done       = (phase == PH_DONE) && !val_q;
    assign o_gen_count  = gen_cnt;
    assign o_sent_count = sent_cnt;

endmodule

// File: tb/tb_node_traffic_gen.sv
// Directed bench for node_traffic_gen: full-rate run, zero-count phases, zero rate,
// destination range, stall hold and mid-MEASURE reset reproducibility.
module tb_node_traffic_gen;
    import node_traffic_gen_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic start;
    logic en_a, en_z, en_k, en_r;

    packet_t     data_a, data_z, data_k, data_r;
    logic        val_a, val_z, val_k, val_r;
    logic        meas_a, meas_z, meas_k, meas_r;
    logic [2:0]  ph_a, ph_z, ph_k, ph_r;
    logic        done_a, done_z, done_k, done_r;
    logic [31:0] gen_a, gen_z, gen_k, gen_r;
    logic [31:0] sent_a, sent_z, sent_k, sent_r;

    int errors = 0;
    int checks = 0;

    logic [15:0] lfsr_m;
    logic [15:0] exp_q[$];
    logic [15:0] rec [8];
    int          exp_meas [6] = '{0, 0, 1, 1, 1, 0};
    int          exp_ph   [6] = '{1, 2, 2, 2, 3, 4};

    // ---------------- clock / DUTs ----------------
    always #5 clk = ~clk;

    node_traffic_gen #(.X_LOC(1), .Y_LOC(2), .PACKET_RATE(100),
                       .WARMUP_PACKETS(2), .MEASURE_PACKETS(3), .DRAIN_PACKETS(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .i_start(start), .i_en(en_a),
        .o_data(data_a), .o_data_val(val_a), .o_measure(meas_a), .o_phase(ph_a),
        .o_done(done_a), .o_gen_count(gen_a), .o_sent_count(sent_a));

    node_traffic_gen #(.PACKET_RATE(0)) dut_z (
        .clk(clk), .reset_n(reset_n), .i_start(start), .i_en(en_z),
        .o_data(data_z), .o_data_val(val_z), .o_measure(meas_z), .o_phase(ph_z),
        .o_done(done_z), .o_gen_count(gen_z), .o_sent_count(sent_z));

    node_traffic_gen #(.X_LOC(3), .Y_LOC(3), .PACKET_RATE(100),
                       .WARMUP_PACKETS(0), .MEASURE_PACKETS(0), .DRAIN_PACKETS(4)) dut_k (
        .clk(clk), .reset_n(reset_n), .i_start(start), .i_en(en_k),
        .o_data(data_k), .o_data_val(val_k), .o_measure(meas_k), .o_phase(ph_k),
        .o_done(done_k), .o_gen_count(gen_k), .o_sent_count(sent_k));

    node_traffic_gen #(.X_NODES(3), .Y_NODES(5), .X_LOC(2), .Y_LOC(4), .PACKET_RATE(100),
                       .WARMUP_PACKETS(4), .MEASURE_PACKETS(20000), .DRAIN_PACKETS(0)) dut_r (
        .clk(clk), .reset_n(reset_n), .i_start(start), .i_en(en_r),
        .o_data(data_r), .o_data_val(val_r), .o_measure(meas_r), .o_phase(ph_r),
        .o_done(done_r), .o_gen_count(gen_r), .o_sent_count(sent_r));

    // ---------------- reference model ----------------
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    function automatic logic [15:0] pack_a(input logic [15:0] l);
        return {4'd1, 4'd2, 4'(int'(l[15:12]) % 4), 4'(int'(l[13:10]) % 4)};
    endfunction

    function automatic logic [15:0] pack_r(input logic [15:0] l);
        return {4'd2, 4'd4, 4'(int'(l[15:12]) % 3), 4'(int'(l[13:10]) % 5)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock; the model LFSR tracks the DUT LFSR; outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        lfsr_m = reset_n ? lfsr_step(lfsr_m) : 16'hACE1;
        #1;
    endtask

    task automatic release_and_start();
        reset_n = 1'b1;
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [14:0] seen;
        int          r_bad;
        logic        z_val_seen;
        logic [15:0] d0;
        logic        m0;
        logic [31:0] g0;
        logic [15:0] e;

        lfsr_m  = 16'hACE1;
        reset_n = 1'b0;
        start   = 1'b0;
        en_a = 1'b1; en_z = 1'b1; en_k = 1'b1; en_r = 1'b1;
        step();
        step();

        check("rst_data", data_a, 32'h1200);
        check("rst_val", val_a, 0);
        check("rst_meas", meas_a, 0);
        check("rst_phase", ph_a, 0);
        check("rst_done", done_a, 0);
        check("rst_gen", gen_a, 0);
        check("rst_sent", sent_a, 0);

        release_and_start();
        check("start_ph_a", ph_a, 1);
        check("start_val_a", val_a, 0);
        check("start_ph_k", ph_k, 3);
        check("start_ph_z", ph_z, 1);
        check("start_ph_r", ph_r, 1);

        // Full-rate run, zero-count phases and first packets of the range node.
        for (int i = 1; i <= 8; i++) begin
            if (i <= 6) exp_q.push_back(pack_a(lfsr_m));
            e = pack_r(lfsr_m);
            step();
            rec[i-1] = data_r;
            check("r_pkt", data_r, e);
            if (i <= 6) begin
                check("a_val", val_a, 1);
                check("a_data", data_a, exp_q.pop_front());
                check("a_meas", meas_a, exp_meas[i-1]);
                check("a_phase", ph_a, exp_ph[i-1]);
                check("a_gen", gen_a, i);
                check("a_sent", sent_a, i - 1);
            end
            if (i == 6) check("a_done_early", done_a, 0);
            if (i == 7) begin
                check("a_val_end", val_a, 0);
                check("a_done", done_a, 1);
                check("a_gen_end", gen_a, 6);
                check("a_sent_end", sent_a, 6);
                check("a_phase_end", ph_a, 4);
            end
            if (i <= 4) begin
                check("k_val", val_k, 1);
                check("k_meas", meas_k, 0);
                check("k_src", data_k[15:8], 8'h33);
            end
            if (i == 4) check("k_phase_done", ph_k, 4);
            if (i == 5) begin
                check("k_done", done_k, 1);
                check("k_gen", gen_k, 4);
            end
        end

        // Long run: destination range, model agreement, zero-rate node stays silent.
        seen = '0;
        r_bad = 0;
        z_val_seen = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            e = pack_r(lfsr_m);
            step();
            z_val_seen |= val_z;
            if (data_r.x_dest >= 4'd3 || data_r.y_dest >= 4'd5 ||
                data_r.x_source != 4'd2 || data_r.y_source != 4'd4 || data_r !== e || !val_r)
                r_bad++;
            else
                seen[int'(data_r.x_dest) * 5 + int'(data_r.y_dest)] = 1'b1;
        end
        check("r_range_bad", r_bad, 0);
        check("r_cover", seen, 15'h7fff);
        check("r_phase", ph_r, 2);
        check("r_meas", meas_r, 1);
        check("z_val_never", z_val_seen, 0);
        check("z_phase", ph_z, 1);
        check("z_gen", gen_z, 0);

        // Stall hold.
        en_r = 1'b0;
        d0 = data_r;
        m0 = meas_r;
        g0 = gen_r;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_val", val_r, 1);
            check("stall_data", data_r, d0);
            check("stall_meas", meas_r, m0);
        end
        check("stall_gen_le1", (gen_r - g0) <= 32'd1, 1);

        // Reset mid-MEASURE with a held packet.
        check("pre_rst_ph_r", ph_r, 2);
        reset_n = 1'b0;
        step();
        check("mid_rst_data", data_r, 32'h2400);
        check("mid_rst_val", val_r, 0);
        check("mid_rst_meas", meas_r, 0);
        check("mid_rst_phase", ph_r, 0);
        check("mid_rst_done", done_r, 0);
        check("mid_rst_gen", gen_r, 0);
        check("mid_rst_sent", sent_r, 0);
        step();
        en_r = 1'b1;
        release_and_start();
        for (int i = 0; i < 8; i++) begin
            step();
            check("repeat_pkt", data_r, rec[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/node_traffic_gen.md
# node_traffic_gen

Synthesizable per-node traffic source for the mesh network. It produces Bernoulli-injected packets with random in-mesh destinations and runs a warm-up/measure/drain phase sequence. It feeds the per-node `fifo_packet` input queue (`i_data`/`i_data_val`, backpressured by that queue's `o_en`), and replaces behavioural `$urandom` stimulus so that traffic generation is identical in simulation and on FPGA. One instance is used per node.

## Interface
Parameters:
- `X_NODES`, default 4: mesh width. Range 1..16.
- `Y_NODES`, default 4: mesh height. Range 1..16.
- `X_LOC`, default 0: this node's x coordinate. Driven into `x_source`.
- `Y_LOC`, default 0: this node's y coordinate. Driven into `y_source`.
- `PACKET_RATE`, default 100: offered load, in percent, 0..100.
- `WARMUP_PACKETS`, default 1000: packets generated in WARMUP.
- `MEASURE_PACKETS`, default 5000: packets generated in MEASURE.
- `DRAIN_PACKETS`, default 3000: packets generated in DRAIN.
- `SEED`, default 16'hACE1: LFSR reset value. Must be nonzero.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `i_start` in 1: level; leaves IDLE when high.
- `i_en` in 1: downstream queue can accept a packet this cycle.
- `o_data` out packet_t: packet held for transfer.
- `o_data_val` out 1: `o_data` is valid.
- `o_measure` out 1: tags the held packet as a measurement packet.
- `o_phase` out 3: current phase. IDLE=0, WARMUP=1, MEASURE=2, DRAIN=3, DONE=4.
- `o_done` out 1: in DONE and holding register empty.
- `o_gen_count` out 32: packets generated since reset.
- `o_sent_count` out 32: packets transferred since reset.

## Operation
- **LFSR:** 16-bit Galois, taps 16'hB400, loaded with `SEED` at reset. It advances exactly once per cycle when not in reset, regardless of phase or stall.
- **Draw:** made each cycle from the current LFSR state `L`.
  - `hit = {1'b0, L[9:0]} < THRESH`, where `THRESH = (PACKET_RATE*1024)/100`, floor, 11 bits.
  - `PACKET_RATE=100` gives 1024, so every draw hits. `PACKET_RATE=0` means no draw ever hits.
  - `x_dest = L[15:12] % X_NODES`; `y_dest = L[13:10] % Y_NODES`. The modulo bias is accepted.
- **Holding register:** one entry; `o_data_val` marks it occupied.
  - Transfer occurs when `o_data_val && i_en`.
  - Load condition: phase ∈ {WARMUP, MEASURE, DRAIN} and `hit` and (register empty or transfer this cycle).
  - On load, next cycle:
    - `o_data = {X_LOC, Y_LOC, x_dest, y_dest}`;
    - `o_data_val = 1`;
    - `o_measure = (phase == MEASURE)`;
    - `o_gen_count` and the phase counter increment.
  - Transfer with no load: `o_data_val` clears next cycle. `o_data` keeps its last value.
  - No draw is stored while the register is full. Non-loaded hits are discarded (source-side drop), not queued.
- **Phase FSM:**
  - IDLE → WARMUP when `i_start`.
  - WARMUP → MEASURE when the load brings the phase counter to `WARMUP_PACKETS`.
  - MEASURE → DRAIN when the load brings the phase counter to `MEASURE_PACKETS`.
  - DRAIN → DONE when the load brings the phase counter to `DRAIN_PACKETS`.
  - The phase counter clears on every phase change.
  - A phase with a zero count is skipped in the same cycle the FSM enters it, so IDLE can go directly to MEASURE, DRAIN or DONE.
  - DONE is terminal until reset; no loads occur in DONE.
- **Counters:** 32-bit, wrap modulo 2^32. `o_sent_count` increments on each transfer.
- A packet loaded in one phase and transferred in a later phase keeps its load-time `o_measure`.

## Timing
- **Reset values:**
  - `o_data = {X_LOC, Y_LOC, 0, 0}`
  - `o_data_val = 0`, `o_measure = 0`
  - `o_phase = IDLE`, `o_done = 0`
  - both counts 0; LFSR = `SEED`
- Reset asserted mid-operation takes effect at the next edge. A held packet is discarded.
- `i_start` sampled high at edge t: `o_phase = WARMUP` after t. The first packet can be valid after t+1.
- Draw at cycle t produces `o_data_val` at t+1, i.e. one-cycle latency.
- Sustained throughput with `PACKET_RATE=100` and `i_en=1` is one packet per cycle.
- `o_data` and `o_measure` must be stable while `o_data_val=1 && i_en=0`.
- `o_done` goes high the cycle after the last packet's transfer, or the cycle after entering DONE if the register is already empty.

## Test plan
- **Full-rate run:** `PACKET_RATE=100`, W=2/M=3/D=1, `i_en=1`, pulse `i_start`.
  - Exactly 6 packets on consecutive cycles.
  - `o_measure` = 0,0,1,1,1,0.
  - `o_phase` steps 1→2→3→4.
  - `o_done` one cycle after the 6th transfer; final counts 6/6.
- **Stall hold:** mid-run, hold `i_en=0` for 5 cycles.
  - `o_data` and `o_measure` stay constant and `o_data_val` stays 1.
  - `o_gen_count` increases by at most 1 packet (the one already held).
- **Zero rate:** `PACKET_RATE=0`, 2000 cycles.
  - `o_data_val` never asserts; phase stays WARMUP.
- **Zero-count phases:** W=0, M=0, D=4.
  - IDLE→DRAIN in one cycle.
  - 4 packets, all with `o_measure=0`; then DONE.
- **Destination range:** `X_NODES=3`, `Y_NODES=5`, 10,000 packets.
  - Every `x_dest` < 3 and `y_dest` < 5; every value is hit.
  - Source fields always equal `X_LOC`/`Y_LOC`.
- **Reset mid-MEASURE with a held packet:** all outputs return to reset values next cycle.
  - After re-start, the same `SEED` reproduces an identical packet sequence.
